// File: rtl/tt_scan_pkg.sv
// Shared widths, vector count and FSM state encoding for the truth-table scanner.
package tt_scan_pkg;

  localparam int VEC_W = 4;
  localparam int N_VEC = 16;
  localparam logic [VEC_W-1:0] IDX_LAST = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/tt_settle_timer.sv
// Settle-window counter: runs 0..SETTLE_CYCLES-1 while clear is low, pulsing tick on the last count.
module tt_settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam logic [3:0] LAST = 4'(SETTLE_CYCLES - 1);

  logic [3:0] cnt;

  assign tick = !clear && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 4'd0;
    end else if (clear || tick) begin
      cnt <= 4'd0;
    end else begin
      cnt <= cnt + 4'd1;
    end
  end

endmodule

// File: rtl/tt_scanner.sv
// Drives all 16 input vectors to a 4-in/1-out function, captures its truth table and compares it with EXPECTED.
// Optional first-mismatch reporting is enabled by defining TT_SCAN_FAILIDX_EN.
module tt_scanner
  import tt_scan_pkg::*;
#(
  parameter int               SETTLE_CYCLES = 2,
  parameter logic [N_VEC-1:0] EXPECTED      = 16'h7310
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             resp,
  output logic [VEC_W-1:0] vec,
  output logic             busy,
  output logic             done,
  output logic [N_VEC-1:0] table_o,
  output logic             pass
`ifdef TT_SCAN_FAILIDX_EN
  ,
  output logic             fail_valid,
  output logic [VEC_W-1:0] fail_idx
`endif
);

  state_t           state;
  logic [VEC_W-1:0] idx;
  logic             tick;

  // Timer is held at zero outside HOLD so every scan starts with a full window.
  tt_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .clear(state != HOLD),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      vec     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      table_o <= '0;
      pass    <= 1'b0;
`ifdef TT_SCAN_FAILIDX_EN
      fail_valid <= 1'b0;
      fail_idx   <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= HOLD;
            idx     <= '0;
            vec     <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
            table_o <= '0;
            pass    <= 1'b0;
`ifdef TT_SCAN_FAILIDX_EN
            fail_valid <= 1'b0;
            fail_idx   <= '0;
`endif
          end
        end
        HOLD: begin
          if (tick) begin
            table_o[idx] <= resp;
`ifdef TT_SCAN_FAILIDX_EN
            if (!fail_valid && (resp != EXPECTED[idx])) begin
              fail_valid <= 1'b1;
              fail_idx   <= idx;
            end
`endif
            if (idx == IDX_LAST) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              // The final sample is not yet in table_o, so splice it in for the compare.
              pass  <= ({resp, table_o[N_VEC-2:0]} == EXPECTED);
            end else begin
              idx <= idx + 4'd1;
              vec <= idx + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
